// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-controller-side signals of the two-port memory arbiter.
// slave is the arbiter's view; master is the environment's view (requesters plus controller).
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        type0;
    logic        type1;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_request;
    logic        mem_request_type;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic [15:0] mem_data_in;
    logic        mem_ready;
    logic        mem_write_complete;

    modport slave (
        input  req0, req1, type0, type1, addr0, addr1, wdata0, wdata1,
        input  mem_data_in, mem_ready, mem_write_complete,
        output ack0, ack1, err0, err1, rdata, busy,
        output mem_request, mem_request_type, mem_address, mem_write_data
    );

    modport master (
        output req0, req1, type0, type1, addr0, addr1, wdata0, wdata1,
        output mem_data_in, mem_ready, mem_write_complete,
        input  ack0, ack1, err0, err1, rdata, busy,
        input  mem_request, mem_request_type, mem_address, mem_write_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller request port between two masters,
// one transaction in flight at a time, with a WAIT-state timeout producing an error ack.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned TW      = 13
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          type_q, type_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;
    logic          busy_q, busy_d;
    logic          mem_req_q, mem_req_d;

    logic grant1;
    logic hit;
    logic finish;
    logic timed_out;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = '0;
        cnt_d     = cnt_q;
        finish    = 1'b0;
        timed_out = 1'b0;
        grant1    = bus.req1 && (!bus.req0 || !last_q);
        hit       = type_q ? bus.mem_write_complete : bus.mem_ready;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = ISSUE;
                    owner_d = grant1;
                    type_d  = grant1 ? bus.type1  : bus.type0;
                    addr_d  = grant1 ? bus.addr1  : bus.addr0;
                    wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the final timeout cycle still counts as success.
                if (hit) begin
                    state_d = DONE;
                    finish  = 1'b1;
                    rdata_d = type_q ? 16'h0000 : bus.mem_data_in;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    rdata_d   = '1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        ack0_d    = finish && !owner_q;
        ack1_d    = finish && owner_q;
        err0_d    = timed_out && !owner_q;
        err1_d    = timed_out && owner_q;
        mem_req_d = (state_d == ISSUE);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            type_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            busy_q    <= busy_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign bus.ack0             = ack0_q;
    assign bus.ack1             = ack1_q;
    assign bus.err0             = err0_q;
    assign bus.err1             = err1_q;
    assign bus.rdata            = rdata_q;
    assign bus.busy             = busy_q;
    assign bus.mem_request      = mem_req_q;
    assign bus.mem_request_type = type_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT=8): directed transactions push expected
// issues and completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(8), .TW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [15:0] rdata;
    } cmp_t;

    typedef struct packed {
        logic        typ;
        logic [15:0] addr;
        logic [15:0] wdata;
    } iss_t;

    cmp_t exp_cmp[$];
    iss_t exp_iss[$];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          iss_prev = 0;
    int          iss_last = 0;
    bit          ctl_auto = 1'b0;
    int unsigned ctl_lat  = 1;
    logic [15:0] ctl_data = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected completion, every mem_request one expected issue.
    always @(negedge clk) begin : monitor
        cmp_t c;
        iss_t s;
        if (reset) begin
            if (bus.ack0 || bus.ack1) begin
                if (exp_cmp.size() == 0) begin
                    check("unexpected_ack", {bus.ack1, bus.ack0}, 2'b00);
                end else begin
                    c = exp_cmp.pop_front();
                    check("ack_port", {bus.ack1, bus.ack0}, c.port ? 2'b10 : 2'b01);
                    check("ack_err", {bus.err1, bus.err0},
                          c.err ? (c.port ? 2'b10 : 2'b01) : 2'b00);
                    check("ack_rdata", bus.rdata, c.rdata);
                end
            end else begin
                check("quiet_err_rdata", {bus.err1, bus.err0, bus.rdata}, 18'h0);
            end
            if (bus.mem_request) begin
                iss_prev = iss_last;
                iss_last = cyc;
                if (exp_iss.size() == 0) begin
                    check("unexpected_issue", bus.mem_request, 1'b0);
                end else begin
                    s = exp_iss.pop_front();
                    check("issue_fields",
                          {bus.mem_request_type, bus.mem_address, bus.mem_write_data}, s);
                end
            end
        end
    end

    // Automatic memory-controller model: pulses the type-matching completion ctl_lat cycles
    // after each mem_request.
    initial begin : controller
        forever begin
            @(negedge clk);
            if (bus.mem_request && ctl_auto) begin
                repeat (ctl_lat) @(negedge clk);
                if (bus.mem_request_type) begin
                    bus.mem_write_complete = 1'b1;
                end else begin
                    bus.mem_ready   = 1'b1;
                    bus.mem_data_in = ctl_data;
                end
                @(negedge clk);
                bus.mem_ready          = 1'b0;
                bus.mem_write_complete = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic serve(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bit seen;
            seen = 1'b0;
            for (int unsigned t = 0; t < 40 && !seen; t++) begin
                @(negedge clk);
                if (bus.ack0) begin seen = 1'b1; bus.req0 = 1'b0; end
                if (bus.ack1) begin seen = 1'b1; bus.req1 = 1'b0; end
            end
            if (!seen) check("ack_wait_bound", 1'b0, 1'b1);
        end
    endtask

    function automatic logic [54:0] all_outputs();
        return {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.busy, bus.mem_request,
                bus.mem_request_type, bus.rdata, bus.mem_address, bus.mem_write_data};
    endfunction

    initial begin : driver
        logic acc;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.type0 = 1'b0; bus.type1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_data_in = '0; bus.mem_ready = 1'b0; bus.mem_write_complete = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs", all_outputs(), 55'h0);

        // Simultaneous writes straight after reset: port 0 first, port 1 four cycles later.
        ctl_auto = 1'b1; ctl_lat = 1;
        reset = 1'b1;
        bus.req0 = 1'b1; bus.type0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 16'hAAAA;
        bus.req1 = 1'b1; bus.type1 = 1'b1; bus.addr1 = 16'h0020; bus.wdata1 = 16'h5555;
        exp_iss.push_back('{1'b1, 16'h0010, 16'hAAAA});
        exp_iss.push_back('{1'b1, 16'h0020, 16'h5555});
        exp_cmp.push_back('{1'b0, 1'b0, 16'h0000});
        exp_cmp.push_back('{1'b1, 1'b0, 16'h0000});
        tick();
        check("pairA_issue_latency", {bus.mem_request, bus.mem_address}, {1'b1, 16'h0010});
        serve(2);
        check("pairA_spacing", iss_last - iss_prev, 4);
        tick();

        // Single read on port 0, mem_ready 5 cycles after mem_request.
        ctl_lat = 5; ctl_data = 16'hBEEF;
        bus.req0 = 1'b1; bus.type0 = 1'b0; bus.addr0 = 16'h1234; bus.wdata0 = 16'h0000;
        exp_iss.push_back('{1'b0, 16'h1234, 16'h0000});
        exp_cmp.push_back('{1'b0, 1'b0, 16'hBEEF});
        tick();
        check("read_issue", {bus.mem_request, bus.busy}, 2'b11);
        serve(1);
        tick();
        check("read_idle_after", bus.busy, 1'b0);

        // Second tie with last=0: port 1 first, then port 0.
        ctl_lat = 1;
        bus.req0 = 1'b1; bus.type0 = 1'b1; bus.addr0 = 16'h0030; bus.wdata0 = 16'h1111;
        bus.req1 = 1'b1; bus.type1 = 1'b1; bus.addr1 = 16'h0040; bus.wdata1 = 16'h2222;
        exp_iss.push_back('{1'b1, 16'h0040, 16'h2222});
        exp_iss.push_back('{1'b1, 16'h0030, 16'h1111});
        exp_cmp.push_back('{1'b1, 1'b0, 16'h0000});
        exp_cmp.push_back('{1'b0, 1'b0, 16'h0000});
        serve(2);
        check("pairB_spacing", iss_last - iss_prev, 4);
        tick();

        // Write on port 1 with a stray mem_ready before the real mem_write_complete.
        ctl_auto = 1'b0;
        bus.req1 = 1'b1; bus.type1 = 1'b1; bus.addr1 = 16'h00FF; bus.wdata1 = 16'hC0DE;
        exp_iss.push_back('{1'b1, 16'h00FF, 16'hC0DE});
        exp_cmp.push_back('{1'b1, 1'b0, 16'h0000});
        tick();
        check("wrong_issue_latency", bus.mem_request, 1'b1);
        tick();
        bus.mem_ready = 1'b1; bus.mem_data_in = 16'hDEAD;
        tick();
        bus.mem_ready = 1'b0;
        acc = bus.ack0 | bus.ack1;
        tick(); acc |= bus.ack0 | bus.ack1;
        tick(); acc |= bus.ack0 | bus.ack1;
        bus.mem_write_complete = 1'b1;
        tick();
        bus.mem_write_complete = 1'b0;
        check("wrong_ready_ignored", acc, 1'b0);
        check("wc_ack_next_cycle", bus.ack1, 1'b1);
        bus.req1 = 1'b0;
        tick();

        // Timeout: ack0+err0 in cycle N+10, late completion in DONE ignored.
        bus.req0 = 1'b1; bus.type0 = 1'b0; bus.addr0 = 16'h0100; bus.wdata0 = 16'h0000;
        exp_iss.push_back('{1'b0, 16'h0100, 16'h0000});
        exp_cmp.push_back('{1'b0, 1'b1, 16'hFFFF});
        acc = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            acc |= bus.ack0 | bus.ack1;
        end
        tick();
        check("timeout_no_early_ack", acc, 1'b0);
        check("timeout_ack_cycle", {bus.ack0, bus.err0}, 2'b11);
        bus.req0 = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_data_in = 16'h1234;
        tick();
        bus.mem_ready = 1'b0;
        check("timeout_back_idle", bus.busy, 1'b0);
        tick();
        check("late_completion_ignored", {bus.busy, bus.mem_request}, 2'b00);

        // Completion in the 8th WAIT cycle beats the timeout.
        bus.req0 = 1'b1; bus.type0 = 1'b0; bus.addr0 = 16'h0200; bus.wdata0 = 16'h0000;
        exp_iss.push_back('{1'b0, 16'h0200, 16'h0000});
        exp_cmp.push_back('{1'b0, 1'b0, 16'h5A5A});
        repeat (9) tick();
        bus.mem_ready = 1'b1; bus.mem_data_in = 16'h5A5A;
        tick();
        bus.mem_ready = 1'b0;
        check("race_ack_cycle", {bus.ack0, bus.err0}, 2'b10);
        bus.req0 = 1'b0;
        tick();

        // Reset during WAIT drops the transaction silently.
        bus.req1 = 1'b1; bus.type1 = 1'b0; bus.addr1 = 16'h0777; bus.wdata1 = 16'h0000;
        exp_iss.push_back('{1'b0, 16'h0777, 16'h0000});
        repeat (3) tick();
        check("pre_reset_busy", bus.busy, 1'b1);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", all_outputs(), 55'h0);
        bus.req1 = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        acc = 1'b0;
        repeat (3) begin
            tick();
            acc |= bus.ack0 | bus.ack1 | bus.busy;
        end
        check("no_ack_after_reset", acc, 1'b0);

        ctl_auto = 1'b1; ctl_lat = 2; ctl_data = 16'h1357;
        bus.req0 = 1'b1; bus.type0 = 1'b0; bus.addr0 = 16'h0ABC; bus.wdata0 = 16'h0000;
        exp_iss.push_back('{1'b0, 16'h0ABC, 16'h0000});
        exp_cmp.push_back('{1'b0, 1'b0, 16'h1357});
        tick();
        check("post_reset_issue", {bus.mem_request, bus.mem_address}, {1'b1, 16'h0ABC});
        serve(1);
        repeat (3) tick();

        check("cmp_queue_drained", exp_cmp.size(), 0);
        check("iss_queue_drained", exp_iss.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request arbiter that shares the single memory-controller request interface between the CPU (port 0) and a secondary master such as a UART loader or DMA (port 1). It latches one request at a time, issues it to the memory controller, and waits for the matching completion. It returns read data plus a one-cycle acknowledge to the owning port, and errors out any transaction that exceeds a timeout. The block sits between the requesters and the memory controller in the top level.

## Interface
Parameters:
- TIMEOUT, 4096: maximum cycles spent in WAIT before an error completion; legal range 2..8191.
- TW, 13: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (low = in reset).
- req0 / req1  in  1  port request; held high with type/addr/wdata stable until ack.
- type0 / type1  in  1  0 = read, 1 = write.
- addr0 / addr1  in  16  word address.
- wdata0 / wdata1  in  16  write data; ignored for reads.
- ack0 / ack1  out  1  one-cycle completion pulse to the owning port.
- err0 / err1  out  1  high together with ack when the transaction timed out.
- rdata  out  16  read data; valid only in an ack cycle.
- busy  out  1  high whenever the state is not IDLE.
- mem_request  out  1  one-cycle request pulse to the memory controller.
- mem_request_type  out  1  latched type.
- mem_address  out  16  latched address.
- mem_write_data  out  16  latched write data.
- mem_data_in  in  16  read data from the controller.
- mem_ready  in  1  read-completion pulse.
- mem_write_complete  in  1  write-completion pulse.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - No req: stay.
  - One req: grant that port.
  - Both req: grant the port that is not `last` (round-robin).
  - On grant: latch owner, type, addr and wdata into mem_request_type, mem_address and mem_write_data; go to ISSUE.
- ISSUE: mem_request=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - The completion signal that counts is mem_ready for reads and mem_write_complete for writes. The other completion signal is ignored.
  - On the matching completion: capture mem_data_in into rdata (reads only; writes leave rdata at 0); go to DONE with err clear.
  - Otherwise, if counter == TIMEOUT-1: rdata=16'hFFFF; go to DONE with err set.
  - Otherwise counter += 1 (TW bits, never wraps because of the parameter rule).
- DONE: ack[owner]=1 and err[owner] as determined in WAIT, for one cycle; last=owner; go to IDLE. At DONE exit, rdata and err return to 0.
- Completion and timeout in the same WAIT cycle: completion wins, no error.
- Completion pulses arriving in IDLE, ISSUE or DONE are ignored.
- Requests are never preempted, and only one transaction is outstanding at a time.
- The non-owning port's req is ignored until the next IDLE.
- Reset (async, low):
  - State goes to IDLE and last=1, so port 0 wins the first tie.
  - All outputs are 0, including mem_address, mem_write_data and rdata.
  - An in-flight transaction is dropped silently with no ack and no err.

## Timing
- req sampled high in IDLE at cycle N: mem_request high in cycle N+1 (ISSUE). WAIT starts in N+2.
- Matching completion sampled in cycle M (WAIT): ack/rdata/err valid in cycle M+1 (DONE). IDLE in M+2.
- Requester rule: req must be low by cycle M+2, i.e. dropped on the edge that ends the ack cycle. A req still high in M+2 is treated as a new request.
- Minimum transaction: completion in the first WAIT cycle gives ack 3 cycles after the req sample (N+3). Back-to-back grants are spaced 4 cycles apart.
- Timeout: no completion gives ack+err in cycle N+2+TIMEOUT.
- busy is high from N+1 through M+1 inclusive.
- mem_address, mem_request_type and mem_write_data stay stable from N+1 until the next grant.

## Test plan
- Single read on port 0: addr0=16'h1234, type0=0. Controller pulses mem_ready 5 cycles after mem_request with data 16'hBEEF. Required: mem_request is one cycle with mem_address=16'h1234; ack0 for one cycle with rdata=16'hBEEF and err0=0; ack1 never asserts.
- Simultaneous req0 and req1 (writes, addr 16'h0010 and 16'h0020) straight after reset. Required: port 0 is served first, then port 1 with no extra IDLE beyond the 4-cycle spacing. A second simultaneous pair is then served in the order port 1, port 0.
- Wrong completion: port 1 write to 16'h00FF; controller pulses mem_ready, then 3 cycles later mem_write_complete. Required: mem_ready is ignored; ack1 follows the mem_write_complete by one cycle.
- Timeout with TIMEOUT=8: read with no completion. Required: ack0 and err0 high in cycle N+10 with rdata=16'hFFFF. A completion arriving one cycle later is ignored.
- Completion and timeout in the same cycle (TIMEOUT=8): mem_ready in the 8th WAIT cycle. Required: err0=0 and rdata equals mem_data_in.
- Reset asserted during WAIT, then released. Required: all outputs are 0 immediately (asynchronous); no ack is issued; the first request after release gets its mem_request one cycle after it is sampled.
